// File: rtl/fp_pkg.sv
// Shared single-precision FP definitions for the FPU datapath blocks
// (float_divider now, the multiplier later).
//   - format constants, canonical quiet NaN and +infinity encodings
//   - operand class typedef and a classifier
//   - divider FSM state encoding
//   - 23-bit leading-zero count, used to normalize denormal operands
package fp_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;

    localparam logic [31:0] QNAN    = 32'h7fc00000;
    localparam logic [31:0] POS_INF = 32'h7f800000;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_DENORM,
        CLS_INF,
        CLS_NAN
    } fp_class_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ROUND,
        DONE
    } fdiv_state_t;

    function automatic fp_class_t classify(input logic [31:0] x);
        if (x[30:23] == 8'h00) return (x[22:0] == 23'd0) ? CLS_ZERO : CLS_DENORM;
        if (x[30:23] == 8'hff) return (x[22:0] == 23'd0) ? CLS_INF  : CLS_NAN;
        return CLS_NORM;
    endfunction

    // Number of leading zeros of a non-zero 23-bit fraction.
    function automatic logic [4:0] lzc23(input logic [22:0] f);
        logic [4:0] n;
        n = 5'd23;
        for (int i = 0; i < 23; i++) begin
            if (f[i]) n = 5'(22 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/float_divider_if.sv
// Operand/result bundle of the sequential FP divider.
//   start      request, sampled only while the divider is idle
//   a, b       dividend / divisor (IEEE-754 single)
//   s          quotient, held until the next result
//   busy       operation in progress
//   ready      one-cycle pulse when s/exception are valid
//   exception  invalid, divide-by-zero or overflow
// master: requester side, slave: divider side.
interface float_divider_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic        busy;
    logic        ready;
    logic        exception;

    modport master (output start, a, b, input  s, busy, ready, exception);
    modport slave  (input  start, a, b, output s, busy, ready, exception);
endinterface

// File: rtl/fp_round_pack.sv
// Combinational round-to-nearest-even and pack stage for single precision.
// Ports:
//   sign      result sign
//   exp       biased exponent, 10-bit signed (may be out of range)
//   mant      26-bit raw mantissa: [25] hidden one, [24:2] fraction,
//             [1] guard, [0] round
//   sticky    OR of all lower discarded bits
//   res       packed IEEE-754 result
//   overflow  exponent reached 255 after rounding (result is signed inf)
// Build option FDIV_DENORM_EN: exponents <= 0 are denormalized (right shift
// with shifted-out bits folded into sticky) instead of flushed to zero.
module fp_round_pack (
    input  logic               sign,
    input  logic signed [9:0]  exp,
    input  logic [25:0]        mant,
    input  logic               sticky,
    output logic [31:0]        res,
    output logic               overflow
);

    // Returns {carry, 24-bit significand} after RNE on mant[25:2].
    function automatic logic [24:0] rne(input logic [25:0] m, input logic st);
        logic up;
        up = m[1] & (m[0] | st | m[2]);
        return {1'b0, m[25:2]} + {24'd0, up};
    endfunction

    logic [24:0]       rnd;
    logic signed [9:0] exp_adj;
`ifdef FDIV_DENORM_EN
    logic signed [9:0] sh;
    logic [4:0]        shamt;
    logic [51:0]       wide;
`endif

    always_comb begin
        overflow = 1'b0;
        rnd      = '0;
        exp_adj  = exp;
        res      = {sign, 31'd0};
`ifdef FDIV_DENORM_EN
        sh    = 10'sd1 - exp;
        shamt = (sh > 10'sd27) ? 5'd27 : sh[4:0];
        wide  = {mant, 26'd0} >> shamt;
        if (exp <= 10'sd0) begin
            // Hidden bit is shifted out of [25]; a round-up that reaches
            // bit 23 lands exactly on the minimum normal encoding.
            rnd = rne(wide[51:26], sticky | (|wide[25:0]));
            res = {sign, 7'd0, rnd[23], rnd[22:0]};
        end else
`endif
        begin
            rnd     = rne(mant, sticky);
            // On carry the significand is 2^24, so the fraction bits are 0.
            exp_adj = exp + (rnd[24] ? 10'sd1 : 10'sd0);
            if (exp_adj >= 10'sd255) begin
                res      = {sign, 8'hff, 23'd0};
                overflow = 1'b1;
            end else if (exp_adj <= 10'sd0) begin
                res = {sign, 31'd0};
            end else begin
                res = {sign, exp_adj[7:0], rnd[22:0]};
            end
        end
    end

endmodule

// File: rtl/float_divider.sv
// Sequential IEEE-754 single-precision divider, s = a / b.
// One quotient bit per clock (radix-2 restoring), 27 iterations, then RNE.
// Fixed latency: ready pulses 29 clocks after the accepting edge.
// Ports:
//   clk   rising-edge clock
//   clr   asynchronous active-high reset
//   bus   float_divider_if.slave (start, a, b -> s, busy, ready, exception)
// Build option FDIV_DENORM_EN: denormal operands are normalized on capture
// and tiny results are denormalized; otherwise both flush to signed zero.
module float_divider
    import fp_pkg::*;
(
    input  logic           clk,
    input  logic           clr,
    float_divider_if.slave bus
);

    fdiv_state_t       state;
    logic [4:0]        cnt;
    logic              busy_r, ready_r, exc_r;
    logic [31:0]       s_r;

    logic              sign_r;
    logic signed [9:0] exp_r;
    logic [25:0]       rem_r, div_r;
    logic [26:0]       q_r;
    logic              spc_r, spc_exc_r;
    logic [31:0]       spc_res_r;
    logic [31:0]       res_r;
    logic              res_exc_r;

    // Exponent and 24-bit significand of a non-zero finite operand.
    function automatic void unpack(input logic [31:0] x,
                                   output logic signed [9:0] e,
                                   output logic [23:0] m);
`ifdef FDIV_DENORM_EN
        logic [4:0] lz;
        lz = lzc23(x[22:0]);
        if (x[30:23] == 8'h00) begin
            m = {1'b0, x[22:0]} << (lz + 5'd1);
            e = -$signed({5'd0, lz});
        end else
`endif
        begin
            e = $signed({2'b00, x[30:23]});
            m = {1'b1, x[22:0]};
        end
    endfunction

    // Capture-side decode
    fp_class_t         ca, cb;
    logic signed [9:0] ea, eb, e_cap;
    logic [23:0]       ma, mb;
    logic              sign_in;
    logic              spc, spc_exc;
    logic [31:0]       spc_res;

    always_comb begin
        ca = classify(bus.a);
        cb = classify(bus.b);
`ifndef FDIV_DENORM_EN
        if (ca == CLS_DENORM) ca = CLS_ZERO;
        if (cb == CLS_DENORM) cb = CLS_ZERO;
`endif
        unpack(bus.a, ea, ma);
        unpack(bus.b, eb, mb);
        e_cap   = ea - eb + $signed(10'(EXP_BIAS));
        sign_in = bus.a[31] ^ bus.b[31];

        spc     = 1'b1;
        spc_exc = 1'b0;
        spc_res = {sign_in, 31'd0};
        if (ca == CLS_NAN || cb == CLS_NAN ||
            (ca == CLS_ZERO && cb == CLS_ZERO) ||
            (ca == CLS_INF  && cb == CLS_INF)) begin
            spc_res = QNAN;
            spc_exc = 1'b1;
        end else if (ca == CLS_INF) begin
            spc_res = {sign_in, POS_INF[30:0]};
        end else if (cb == CLS_ZERO) begin
            spc_res = {sign_in, POS_INF[30:0]};
            spc_exc = 1'b1;
        end else if (ca == CLS_ZERO || cb == CLS_INF) begin
            spc_res = {sign_in, 31'd0};
        end else begin
            spc = 1'b0;
        end
    end

    // Restoring step
    logic [26:0] diff;
    logic        qbit;
    logic [25:0] rem_next;

    always_comb begin
        diff     = {1'b0, rem_r} - {1'b0, div_r};
        qbit     = ~diff[26];
        rem_next = qbit ? (diff[25:0] << 1) : (rem_r << 1);
    end

    // Normalize a ratio below one before rounding
    logic [26:0]       q_n;
    logic signed [9:0] e_n;
    logic [31:0]       rp_res;
    logic              rp_ovf;

    always_comb begin
        q_n = q_r[26] ? q_r : {q_r[25:0], 1'b0};
        e_n = q_r[26] ? exp_r : exp_r - 10'sd1;
    end

    fp_round_pack u_round_pack (
        .sign     (sign_r),
        .exp      (e_n),
        .mant     (q_n[26:1]),
        .sticky   (q_n[0] | (|rem_r)),
        .res      (rp_res),
        .overflow (rp_ovf)
    );

    // Control FSM and registered outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            busy_r <= 1'b0;
            ready_r <= 1'b0;
            s_r    <= 32'd0;
            exc_r  <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state  <= CALC;
                    cnt    <= 5'd26;
                    busy_r <= 1'b1;
                end
                CALC: begin
                    cnt <= (cnt == 5'd0) ? 5'd0 : cnt - 5'd1;
                    if (cnt == 5'd0) state <= ROUND;
                end
                ROUND: state <= DONE;
                DONE: begin
                    state   <= IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                    s_r     <= res_r;
                    exc_r   <= res_exc_r;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath (no reset; contents are qualified by the FSM)
    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (bus.start) begin
                sign_r    <= sign_in;
                exp_r     <= e_cap;
                rem_r     <= {2'b00, ma};
                div_r     <= {2'b00, mb};
                q_r       <= '0;
                spc_r     <= spc;
                spc_res_r <= spc_res;
                spc_exc_r <= spc_exc;
            end
            CALC: begin
                rem_r <= rem_next;
                q_r   <= {q_r[25:0], qbit};
            end
            ROUND: begin
                res_r     <= spc_r ? spc_res_r : rp_res;
                res_exc_r <= spc_r ? spc_exc_r : rp_ovf;
            end
            default: ;
        endcase
    end

    assign bus.s         = s_r;
    assign bus.busy      = busy_r;
    assign bus.ready     = ready_r;
    assign bus.exception = exc_r;

endmodule
